// File: rtl/sp_fifo_pkg.sv
// Generic-FIFO section: per-queue depths and watermark thresholds used when
// each scratchpad queue instantiates sp_fifo.
package sp_fifo_pkg;

  localparam int WFIFO_DEPTH       = 8;
  localparam int WFIFO_AFULL_TH    = WFIFO_DEPTH - 2;
  localparam int WFIFO_AEMPTY_TH   = 1;

  localparam int RFIFO_DEPTH       = 8;
  localparam int RFIFO_AFULL_TH    = RFIFO_DEPTH - 2;
  localparam int RFIFO_AEMPTY_TH   = 1;

  localparam int DFIFO_DEPTH       = 16;
  localparam int DFIFO_AFULL_TH    = DFIFO_DEPTH - 4;
  localparam int DFIFO_AEMPTY_TH   = 2;

  localparam int GEMMFIFO_DEPTH    = 4;
  localparam int GEMMFIFO_AFULL_TH = GEMMFIFO_DEPTH - 1;
  localparam int GEMMFIFO_AEMPTY_TH = 1;

  localparam int IFIFO_DEPTH       = 12;
  localparam int IFIFO_AFULL_TH    = IFIFO_DEPTH - 2;
  localparam int IFIFO_AEMPTY_TH   = 1;

  localparam int PFIFO_DEPTH       = 6;
  localparam int PFIFO_AFULL_TH    = PFIFO_DEPTH - 2;
  localparam int PFIFO_AEMPTY_TH   = 1;

endpackage

// File: rtl/sp_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one
// asynchronous read port (gives the FIFO its first-word-fall-through head).
module sp_fifo_mem #(
  parameter int DATA_W = 71,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is intentionally never reset; the head is don't-care while empty.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sp_fifo.sv
// Parametrised synchronous FWFT FIFO with occupancy count, watermarks,
// synchronous flush and sticky overflow/underflow flags.
module sp_fifo
  import sp_fifo_pkg::*;
#(
  parameter int DATA_W    = 71,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 1,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              err_clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sp_fifo: DEPTH must be >= 2");
  end
  if (!(AEMPTY_TH >= 0 && AEMPTY_TH < AFULL_TH && AFULL_TH <= DEPTH)) begin : g_bad_th
    $error("sp_fifo: need 0 <= AEMPTY_TH < AFULL_TH <= DEPTH");
  end

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic             ov_set;
  logic             un_set;

  // Handshake: a push is taken when wr_en and there is room (a same-cycle
  // pop makes room when full); a pop is taken when rd_en and not empty.
  // Nothing is taken in a flush cycle. There is no write-to-read bypass.
  assign push_ok = wr_en && (!full || rd_en) && !flush;
  assign pop_ok  = rd_en && !empty && !flush;
  assign ov_set  = wr_en && full && !rd_en && !flush;
  assign un_set  = rd_en && empty && !flush;

  // Flags come only from the registered count.
  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_W'(AFULL_TH));
  assign almost_empty = (count <= CNT_W'(AEMPTY_TH));

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
        if (pop_ok)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
        case ({push_ok, pop_ok})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
      // A new error in the same cycle as err_clr wins.
      overflow_err  <= ov_set | (overflow_err  & ~err_clr);
      underflow_err <= un_set | (underflow_err & ~err_clr);
    end
  end

  sp_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .CLK   (CLK),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_sp_fifo.sv
// Bench for sp_fifo (DEPTH=4, AFULL_TH=3, AEMPTY_TH=1, DATA_W=8): directed
// scenarios with literal expectations, then random traffic against a queue model.
module tb_sp_fifo;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 4;
  localparam int AFULL_TH  = 3;
  localparam int AEMPTY_TH = 1;
  localparam int CNT_W     = $clog2(DEPTH + 1);

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              flush = 1'b0;
  logic              err_clr = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              full, empty, almost_full, almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow_err, underflow_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [DATA_W-1:0] exp_q[$];
  logic              m_ov = 1'b0;
  logic              m_un = 1'b0;
  logic              model_live = 1'b0;

  sp_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .flush         (flush),
    .err_clr       (err_clr),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .count         (count),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: updated from the inputs sampled at each rising edge.
  always @(posedge CLK) begin
    bit m_full, m_empty, push, pop, ovs, uns;
    if (RST) begin
      exp_q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
      model_live = 1'b1;
    end else begin
      m_full  = (exp_q.size() == DEPTH);
      m_empty = (exp_q.size() == 0);
      ovs = !flush && wr_en && m_full && !rd_en;
      uns = !flush && rd_en && m_empty;
      if (flush) begin
        exp_q.delete();
      end else begin
        pop  = rd_en && !m_empty;
        push = wr_en && (!m_full || rd_en);
        if (pop)  void'(exp_q.pop_front());
        if (push) exp_q.push_back(wr_data);
      end
      m_ov = ovs ? 1'b1 : (err_clr ? 1'b0 : m_ov);
      m_un = uns ? 1'b1 : (err_clr ? 1'b0 : m_un);
    end
  end

  // Compare process: every falling edge once the model has seen a reset.
  always @(negedge CLK) begin
    if (model_live) begin
      int sz;
      sz = exp_q.size();
      check("count",         32'(count),         32'(sz));
      check("empty",         32'(empty),         32'(sz == 0));
      check("full",          32'(full),          32'(sz == DEPTH));
      check("almost_full",   32'(almost_full),   32'(sz >= AFULL_TH));
      check("almost_empty",  32'(almost_empty),  32'(sz <= AEMPTY_TH));
      check("overflow_err",  32'(overflow_err),  32'(m_ov));
      check("underflow_err", 32'(underflow_err), 32'(m_un));
      if (sz > 0) check("rd_data", 32'(rd_data), 32'(exp_q[0]));
    end
  end

  // Driver: apply one cycle of inputs, return #1 after the edge.
  task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r,
                      input logic f = 1'b0, input logic ec = 1'b0, input logic rs = 1'b0);
    wr_en = w; wr_data = d; rd_en = r; flush = f; err_clr = ec; RST = rs;
    @(posedge CLK);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0; RST = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;

    // Reset
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_ae",    32'(almost_empty), 1);
    check("rst_full",  32'(full), 0);
    check("rst_af",    32'(almost_full), 0);
    check("rst_errs",  32'({overflow_err, underflow_err}), 0);

    // Fill 0x11..0x44
    for (int i = 0; i < 4; i++) begin
      step(1, vals[i], 0);
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_head",  32'(rd_data), 32'h11);
      check("fill_af",    32'(almost_full), 32'(i >= 2));
      check("fill_full",  32'(full), 32'(i == 3));
    end

    // Overflow: 0x55 dropped
    step(1, 8'h55, 0);
    check("ovf_flag",  32'(overflow_err), 1);
    check("ovf_count", 32'(count), 4);
    for (int i = 0; i < 4; i++) begin
      check("ovf_pop_data", 32'(rd_data), 32'(vals[i]));
      step(0, 0, 1);
    end
    check("ovf_drained", 32'(empty), 1);
    step(0, 0, 0, 0, 1);
    check("ovf_clr", 32'(overflow_err), 0);

    // Full + push/pop together, crossing the pointer wrap
    for (int i = 0; i < 4; i++) step(1, vals[i], 0);
    step(1, 8'h55, 1);
    check("pp_count", 32'(count), 4);
    check("pp_no_ovf", 32'(overflow_err), 0);
    check("pp_head", 32'(rd_data), 32'h22);
    for (int i = 0; i < 4; i++) begin
      check("pp_pop_data", 32'(rd_data), (i == 3) ? 32'h55 : 32'(vals[i + 1]));
      step(0, 0, 1);
    end

    // Empty with wr_en=rd_en=1
    step(1, 8'h66, 1);
    check("unf_flag",  32'(underflow_err), 1);
    check("unf_count", 32'(count), 1);
    check("unf_head",  32'(rd_data), 32'h66);
    step(0, 0, 0, 0, 1);
    check("unf_clr", 32'(underflow_err), 0);
    step(0, 0, 1);

    // Flush at count 3 with a push; underflow flag must survive
    step(0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, vals[i], 0);
    step(1, 8'h77, 0, 1);
    check("fl_count", 32'(count), 0);
    check("fl_empty", 32'(empty), 1);
    check("fl_ae",    32'(almost_empty), 1);
    check("fl_unf",   32'(underflow_err), 1);
    step(1, 8'h99, 0);
    check("fl_head",  32'(rd_data), 32'h99);
    step(0, 0, 1, 0, 1);

    // Reset mid-stream at count 2 with wr_en=1
    step(1, 8'hA1, 0);
    step(1, 8'hA2, 0);
    step(1, 8'hA3, 0, 0, 0, 1);
    check("mrst_count", 32'(count), 0);
    check("mrst_flags", 32'({full, empty, almost_full, almost_empty}), 32'b0101);
    check("mrst_errs",  32'({overflow_err, underflow_err}), 0);
    step(1, 8'h88, 0);
    step(1, 8'h89, 0);
    check("mrst_head", 32'(rd_data), 32'h88);

    // Random traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      logic w, r, f, ec, rs;
      w  = ($urandom_range(0, 99) < 55);
      r  = ($urandom_range(0, 99) < 50);
      f  = ($urandom_range(0, 99) < 2);
      ec = ($urandom_range(0, 99) < 5);
      rs = ($urandom_range(0, 999) < 3);
      step(w, DATA_W'($urandom), r, f, ec, rs);
    end

    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
